dm_mem_flags: RTL and testbench
===============================

# dm_mem_flags

Debug-memory flag handler between the hart's debug-ROM bus port and `dm_core_control`. It decodes core accesses to the flag region of debug memory and turns HALTED/GOING/RESUMING/EXCEPTION writes into the registered status pulses and sticky bits the command FSM consumes. It serves the go/resume flag word the parked hart polls, and drives the hart's debug request.

## Interface
- `AW`, default 12: debug-memory byte-address width.
- `HART_ID`, default 0: hart index the block accepts in flag writes.
- `HIDW`, default 10: width of the hart-ID field compared in `wdata_i`.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  core bus request, one access per cycle, no back-pressure.
- `we_i`  in  1  write enable.
- `addr_i`  in  AW  byte address; bits [1:0] ignored.
- `wdata_i`  in  32  write data.
- `be_i`  in  4  byte enables.
- `rdata_o`  out  32  read data, valid with `rvalid_o`.
- `rvalid_o`  out  1  response strobe, one cycle after every `req_i`, reads and writes alike.
- `go_i`  in  1  level from the command FSM; run the abstract command.
- `resume_i`  in  1  level from the command FSM; resume the hart.
- `haltreq_i`  in  1  halt request from dmcontrol.
- `clear_resumeack_i`  in  1  pulse clearing `resuming_q_o`.
- `ndmreset_i`  in  1  non-debug-module reset.
- `halted_o`  out  1  one-cycle pulse on a HALTED write.
- `going_o`  out  1  one-cycle pulse on a GOING write.
- `exception_o`  out  1  one-cycle pulse on an EXCEPTION write.
- `halted_q_o`  out  1  sticky halted status.
- `resuming_q_o`  out  1  sticky resume acknowledge.
- `debug_req_o`  out  1  debug request to the hart.

## Operation
- Flag addresses, word-aligned, from `dm_pkg`:
  - HALTED 0x100
  - GOING 0x104
  - RESUMING 0x108
  - EXCEPTION 0x10C
  - FLAGS 0x400
- A flag write is accepted when all of these hold:
  - `req_i & we_i` is high.
  - The address matches a flag address.
  - `|be_i` is set.
  - `wdata_i[HIDW-1:0]` equals `HART_ID`. A mismatch is silently dropped, but `rvalid_o` still fires.
- Accepted HALTED write:
  - `halted_o` pulses.
  - `halted_q_o` sets.
  - `resuming_q_o` is unchanged.
- Accepted GOING write: `going_o` pulses.
- Accepted EXCEPTION write: `exception_o` pulses.
- Accepted RESUMING write:
  - `halted_q_o` clears.
  - `resuming_q_o` sets.
- `clear_resumeack_i` clears `resuming_q_o`. A RESUMING write in the same cycle wins, so the bit ends set.
- FLAGS read returns `{30'b0, resume_i, go_i}`, sampled in the request cycle.
- Reads of any other address, and all write responses, return `rdata_o` = 0.
- Writes to FLAGS and to unmapped addresses are ignored.
- `debug_req_o` is registered `haltreq_i & ~halted_q_o`. It drops the cycle after `halted_q_o` rises.
- `ndmreset_i` clears `halted_q_o` and `resuming_q_o` and suppresses all pulses that cycle. It overrides any concurrent flag write.

## Timing
- Reset (`rst_i` high at an edge) forces every output to 0: `rdata_o`, `rvalid_o`, all pulses, both sticky bits, `debug_req_o`.
- Reset mid-access discards the access; no `rvalid_o` follows.
- Request in cycle N produces `rvalid_o`/`rdata_o` and any pulse or sticky change in cycle N+1.
- Pulses last exactly one cycle. Back-to-back writes to the same flag give back-to-back pulses.
- `haltreq_i` rising in cycle N raises `debug_req_o` in N+1 (if `halted_q_o` is 0).
- `go_i` visibility: set in cycle N, a FLAGS read issued in N returns bit0 = 1 in N+1.

## Structure
- `dm_pkg` holds:
  - the flag address constants;
  - FLAGS bit indices (GO = 0, RESUME = 1);
  - the shared command-error encodings.
- No sub-module: a single flat module with one address-decode block and one register block.

## Test plan
- Reset release: all outputs 0. Write HALTED with wdata = 0 -> `halted_o` pulse at N+1, `halted_q_o` = 1, `rvalid_o` = 1, `rdata_o` = 0.
- `haltreq_i` = 1 while not halted -> `debug_req_o` = 1 next cycle. Then a HALTED write -> `debug_req_o` = 0 one cycle after `halted_q_o` = 1.
- Flag polling:
  - `go_i` = 1, read 0x400 -> `rdata_o` = 0x1.
  - `resume_i` = 1, `go_i` = 0 -> `rdata_o` = 0x2.
  - GOING write -> single `going_o` pulse.
- Resume handshake and collisions:
  - RESUMING write -> `halted_q_o` = 0, `resuming_q_o` = 1.
  - `clear_resumeack_i` -> `resuming_q_o` = 0.
  - RESUMING write in the same cycle as `clear_resumeack_i` -> `resuming_q_o` = 1.
- Rejected writes:
  - HART_ID = 0, HALTED write with wdata = 5 -> no pulse, `halted_q_o` unchanged, `rvalid_o` = 1.
  - `be_i` = 0 -> ignored.
  - Write to 0x200 -> ignored, `rdata_o` = 0.
- Reset overrides:
  - EXCEPTION write concurrent with `ndmreset_i` -> no `exception_o`, sticky bits 0.
  - `rst_i` asserted the cycle after a request -> `rvalid_o` = 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared debug-module constants: flag addresses in debug memory, FLAGS word
// bit positions and the abstract-command error encodings.
package dm_pkg;

  // Word-aligned byte addresses of the hart-to-DM flag registers.
  localparam logic [31:0] HALTED_ADDR    = 32'h0000_0100;
  localparam logic [31:0] GOING_ADDR     = 32'h0000_0104;
  localparam logic [31:0] RESUMING_ADDR  = 32'h0000_0108;
  localparam logic [31:0] EXCEPTION_ADDR = 32'h0000_010C;
  localparam logic [31:0] FLAGS_ADDR     = 32'h0000_0400;

  // Bit positions inside the FLAGS word polled by the parked hart.
  localparam int unsigned FLAG_GO     = 0;
  localparam int unsigned FLAG_RESUME = 1;

  // Index of each writable flag in the decode vector.
  localparam int unsigned NUM_FLAGS     = 4;
  localparam int unsigned IDX_HALTED    = 0;
  localparam int unsigned IDX_GOING     = 1;
  localparam int unsigned IDX_RESUMING  = 2;
  localparam int unsigned IDX_EXCEPTION = 3;

  // Abstract-command error codes reported through abstractcs.cmderr.
  typedef enum logic [2:0] {
    CMDERR_NONE         = 3'd0,
    CMDERR_BUSY         = 3'd1,
    CMDERR_NOTSUPPORTED = 3'd2,
    CMDERR_EXCEPTION    = 3'd3,
    CMDERR_HALTRESUME   = 3'd4,
    CMDERR_BUS          = 3'd5,
    CMDERR_OTHER        = 3'd7
  } cmderr_e;

  // Flag address for a decode-vector index.
  function automatic logic [31:0] flag_addr(input int unsigned idx);
    case (idx)
      IDX_HALTED:    flag_addr = HALTED_ADDR;
      IDX_GOING:     flag_addr = GOING_ADDR;
      IDX_RESUMING:  flag_addr = RESUMING_ADDR;
      default:       flag_addr = EXCEPTION_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/dm_mem_flags.sv
// Debug-memory flag handler: decodes hart writes to the HALTED / GOING /
// RESUMING / EXCEPTION flags into registered pulses and sticky status, serves
// the FLAGS word the parked hart polls, and drives the hart debug request.
module dm_mem_flags
  import dm_pkg::*;
#(
  parameter int AW      = 12,
  parameter int HART_ID = 0,
  parameter int HIDW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o,
  output logic          rvalid_o,
  input  logic          go_i,
  input  logic          resume_i,
  input  logic          haltreq_i,
  input  logic          clear_resumeack_i,
  input  logic          ndmreset_i,
  output logic          halted_o,
  output logic          going_o,
  output logic          exception_o,
  output logic          halted_q_o,
  output logic          resuming_q_o,
  output logic          debug_req_o
);

  localparam logic [HIDW-1:0] HART_ID_FIELD = HIDW'(HART_ID);

  logic [NUM_FLAGS-1:0] flag_hit;
  logic [NUM_FLAGS-1:0] flag_wr;
  logic                 flags_hit;
  logic                 wr_accept;
  logic [31:0]          rdata_next;

  logic [31:0] rdata_reg;
  logic        rvalid_reg;
  logic        halted_reg;
  logic        going_reg;
  logic        exception_reg;
  logic        halted_q_reg;
  logic        resuming_q_reg;
  logic        debug_req_reg;

  // Byte-lane bits of the address and the upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:HIDW]};

  // Per-flag word-address comparators.
  for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag_decode
    localparam logic [31:0] FLAG_ADDR = flag_addr(gi);
    assign flag_hit[gi] = (addr_i[AW-1:2] == FLAG_ADDR[AW-1:2]);
  end

  // Address decode: qualify flag writes and build the read data for this request.
  always_comb begin
    flags_hit  = (addr_i[AW-1:2] == FLAGS_ADDR[AW-1:2]);
    wr_accept  = req_i & we_i & (|be_i) & (wdata_i[HIDW-1:0] == HART_ID_FIELD);
    // ndmreset suppresses every flag effect in its cycle.
    flag_wr    = (wr_accept & ~ndmreset_i) ? flag_hit : '0;
    rdata_next = '0;
    if (req_i && !we_i && flags_hit) begin
      rdata_next[FLAG_GO]     = go_i;
      rdata_next[FLAG_RESUME] = resume_i;
    end
  end

  // Register block: bus response, status pulses, sticky bits and debug request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_reg      <= '0;
      rvalid_reg     <= 1'b0;
      halted_reg     <= 1'b0;
      going_reg      <= 1'b0;
      exception_reg  <= 1'b0;
      halted_q_reg   <= 1'b0;
      resuming_q_reg <= 1'b0;
      debug_req_reg  <= 1'b0;
    end else begin
      rvalid_reg    <= req_i;
      rdata_reg     <= rdata_next;
      halted_reg    <= flag_wr[IDX_HALTED];
      going_reg     <= flag_wr[IDX_GOING];
      exception_reg <= flag_wr[IDX_EXCEPTION];
      debug_req_reg <= haltreq_i & ~halted_q_reg;

      if (ndmreset_i) begin
        halted_q_reg <= 1'b0;
      end else if (flag_wr[IDX_RESUMING]) begin
        halted_q_reg <= 1'b0;
      end else if (flag_wr[IDX_HALTED]) begin
        halted_q_reg <= 1'b1;
      end

      // A RESUMING write outranks a concurrent acknowledge clear.
      if (ndmreset_i) begin
        resuming_q_reg <= 1'b0;
      end else if (flag_wr[IDX_RESUMING]) begin
        resuming_q_reg <= 1'b1;
      end else if (clear_resumeack_i) begin
        resuming_q_reg <= 1'b0;
      end
    end
  end

  assign rdata_o      = rdata_reg;
  assign rvalid_o     = rvalid_reg;
  assign halted_o     = halted_reg;
  assign going_o      = going_reg;
  assign exception_o  = exception_reg;
  assign halted_q_o   = halted_q_reg;
  assign resuming_q_o = resuming_q_reg;
  assign debug_req_o  = debug_req_reg;

endmodule

// File: tb/tb_dm_mem_flags.sv
// Self-checking bench for dm_mem_flags: a behavioural model pushes the
// expected response for every driven cycle; it is popped and compared after
// the following rising edge.
module tb_dm_mem_flags;

  localparam int AW = 12;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [AW-1:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        go_i;
  logic        resume_i;
  logic        haltreq_i;
  logic        clear_resumeack_i;
  logic        ndmreset_i;
  logic        halted_o;
  logic        going_o;
  logic        exception_o;
  logic        halted_q_o;
  logic        resuming_q_o;
  logic        debug_req_o;

  always #5 clk_i = ~clk_i;

  dm_mem_flags #(.AW(AW), .HART_ID(0), .HIDW(10)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_i             (req_i),
    .we_i              (we_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .be_i              (be_i),
    .rdata_o           (rdata_o),
    .rvalid_o          (rvalid_o),
    .go_i              (go_i),
    .resume_i          (resume_i),
    .haltreq_i         (haltreq_i),
    .clear_resumeack_i (clear_resumeack_i),
    .ndmreset_i        (ndmreset_i),
    .halted_o          (halted_o),
    .going_o           (going_o),
    .exception_o       (exception_o),
    .halted_q_o        (halted_q_o),
    .resuming_q_o      (resuming_q_o),
    .debug_req_o       (debug_req_o)
  );

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        halted;
    logic        going;
    logic        exception;
    logic        halted_q;
    logic        resuming_q;
    logic        debug_req;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Model state.
  logic m_halted_q   = 1'b0;
  logic m_resuming_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL txn=%0d %s: got 0x%0h, expected 0x%0h", txn, tag, actual, expected);
    end
  endtask

  // Compute the expected registered outputs from the inputs now on the bus.
  task automatic model_push();
    exp_t e;
    logic accept;
    logic [9:0] word;
    e = '0;
    if (rst_i) begin
      m_halted_q   = 1'b0;
      m_resuming_q = 1'b0;
    end else begin
      word   = addr_i[11:2];
      accept = req_i && we_i && (be_i != 4'h0) && (wdata_i[9:0] == 10'd0) && !ndmreset_i;
      e.rvalid    = req_i;
      e.rdata     = (req_i && !we_i && word == 10'h100) ? {30'd0, resume_i, go_i} : 32'd0;
      e.halted    = accept && word == 10'h040;
      e.going     = accept && word == 10'h041;
      e.exception = accept && word == 10'h043;
      e.debug_req = haltreq_i && !m_halted_q;
      if (ndmreset_i) begin
        m_halted_q   = 1'b0;
        m_resuming_q = 1'b0;
      end else if (accept && word == 10'h042) begin
        m_halted_q   = 1'b0;
        m_resuming_q = 1'b1;
      end else begin
        if (accept && word == 10'h040) m_halted_q = 1'b1;
        if (clear_resumeack_i) m_resuming_q = 1'b0;
      end
    end
    e.halted_q   = m_halted_q;
    e.resuming_q = m_resuming_q;
    sb_q.push_back(e);
  endtask

  // One clock: predict, advance, compare.
  task automatic step();
    exp_t e;
    model_push();
    @(posedge clk_i);
    #1;
    e = sb_q.pop_front();
    check("rvalid",     32'(rvalid_o),     32'(e.rvalid));
    check("rdata",      rdata_o,           e.rdata);
    check("halted",     32'(halted_o),     32'(e.halted));
    check("going",      32'(going_o),      32'(e.going));
    check("exception",  32'(exception_o),  32'(e.exception));
    check("halted_q",   32'(halted_q_o),   32'(e.halted_q));
    check("resuming_q", 32'(resuming_q_o), 32'(e.resuming_q));
    check("debug_req",  32'(debug_req_o),  32'(e.debug_req));
    $display("txn %0d: rst=%0b req=%0b we=%0b addr=0x%03h wdata=0x%0h be=%0h -> rvalid=%0b rdata=0x%0h pulses=%0b%0b%0b hq=%0b rq=%0b dreq=%0b",
             txn, rst_i, req_i, we_i, addr_i, wdata_i, be_i, rvalid_o, rdata_o,
             halted_o, going_o, exception_o, halted_q_o, resuming_q_o, debug_req_o);
    txn++;
  endtask

  task automatic idle();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = 4'h0;
    step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = b;
    step();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0; be_i = 4'hF;
    step();
  endtask

  initial begin
    logic [AW-1:0] addrs [6];
    addrs = '{12'h100, 12'h104, 12'h108, 12'h10C, 12'h400, 12'h200};

    rst_i = 1'b1; go_i = 1'b0; resume_i = 1'b0; haltreq_i = 1'b0;
    clear_resumeack_i = 1'b0; ndmreset_i = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;

    // Reset, including a request during reset that must not respond.
    step();
    rd(12'h400);
    rst_i = 1'b0;
    idle();

    // Debug request, then HALTED write; request drops one cycle after halted_q.
    haltreq_i = 1'b1;
    idle();
    wr(12'h100, 32'h0, 4'hF);
    idle();
    idle();
    haltreq_i = 1'b0;

    // FLAGS polling.
    go_i = 1'b1;
    rd(12'h400);
    go_i = 1'b0; resume_i = 1'b1;
    rd(12'h400);
    rd(12'h100);
    wr(12'h400, 32'h0, 4'hF);
    resume_i = 1'b0;

    // Back-to-back GOING pulses.
    wr(12'h104, 32'h0, 4'hF);
    wr(12'h104, 32'h0, 4'h1);
    idle();

    // Resume handshake and clear collision.
    wr(12'h108, 32'h0, 4'hF);
    clear_resumeack_i = 1'b1;
    idle();
    clear_resumeack_i = 1'b0;
    wr(12'h100, 32'h0, 4'hF);
    clear_resumeack_i = 1'b1;
    wr(12'h108, 32'h0, 4'hF);
    idle();
    clear_resumeack_i = 1'b0;

    // Rejected writes.
    wr(12'h100, 32'h5, 4'hF);
    wr(12'h10C, 32'h0, 4'h0);
    wr(12'h200, 32'h0, 4'hF);
    rd(12'h200);
    wr(12'h10C, 32'h0, 4'h8);

    // ndmreset overrides a concurrent write and clears sticky bits.
    wr(12'h100, 32'h0, 4'hF);
    wr(12'h108, 32'h0, 4'hF);
    ndmreset_i = 1'b1;
    wr(12'h10C, 32'h0, 4'hF);
    ndmreset_i = 1'b0;
    idle();

    // Reset the cycle after a request discards the response.
    wr(12'h100, 32'h0, 4'hF);
    rd(12'h400);
    rst_i = 1'b1;
    idle();
    rst_i = 1'b0;
    idle();

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      req_i             = 1'($urandom_range(0, 3) != 0);
      we_i              = 1'($urandom_range(0, 1));
      addr_i            = addrs[$urandom_range(0, 5)];
      wdata_i           = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
      be_i              = 4'($urandom_range(0, 15));
      go_i              = 1'($urandom_range(0, 1));
      resume_i          = 1'($urandom_range(0, 1));
      haltreq_i         = 1'($urandom_range(0, 1));
      clear_resumeack_i = 1'($urandom_range(0, 5) == 0);
      ndmreset_i        = 1'($urandom_range(0, 9) == 0);
      rst_i             = 1'($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
